// File: rtl/key_conditioner_pkg.sv
// key_conditioner_pkg -- shared debounce state encoding and parameter defaults.
// Revision 1.0
`default_nettype none

package key_conditioner_pkg;

  typedef enum logic {
    STABLE   = 1'b0,
    SETTLING = 1'b1
  } db_state_t;

  localparam int DB_CYCLES_DEF   = 4;
  localparam int SYNC_STAGES_DEF = 2;

endpackage

`default_nettype wire

// File: rtl/key_conditioner_debounce_cell.sv
// debounce_cell -- input synchronizer plus STABLE/SETTLING debounce FSM with commit pulse.
// Revision 1.0
`default_nettype none

module debounce_cell
  import key_conditioner_pkg::*;
#(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0,
  parameter int               DB_CYCLES   = DB_CYCLES_DEF,
  parameter int               SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] value,
  output logic             chg
);

  localparam int            CW       = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] synced;

  db_state_t        state, state_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [WIDTH-1:0] cand, cand_d;
  logic [WIDTH-1:0] value_d;
  logic             chg_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= RESET_VAL;
    end else begin
      sync_q[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= STABLE;
      cnt   <= '0;
      cand  <= RESET_VAL;
      value <= RESET_VAL;
      chg   <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      cand  <= cand_d;
      value <= value_d;
      chg   <= chg_d;
    end
  end

  // Commit happens on the edge where the counter already sits at DB_CYCLES-1,
  // so the counter never needs to represent DB_CYCLES itself.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    cand_d  = cand;
    value_d = value;
    chg_d   = 1'b0;
    case (state)
      STABLE: begin
        cnt_d = '0;
        if (synced != value) begin
          state_d = SETTLING;
          cand_d  = synced;
        end
      end
      SETTLING: begin
        if (synced == cand) begin
          if (cnt == CNT_LAST) begin
            value_d = cand;
            chg_d   = 1'b1;
            state_d = STABLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end else if (synced == value) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else begin
          cand_d = synced;
          cnt_d  = '0;
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/key_conditioner.sv
// key_conditioner -- debounces calculator switches and the equals key into clean levels and pulses.
// Revision 1.0
`default_nettype none

module key_conditioner
  import key_conditioner_pkg::*;
#(
  parameter int DB_CYCLES   = DB_CYCLES_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic       clk,
  input  logic       ac,
  input  logic [3:0] sw_a,
  input  logic [3:0] sw_b,
  input  logic [2:0] sw_op,
  input  logic       key_eq,
  output logic [3:0] opt_a,
  output logic [3:0] opt_b,
  output logic [2:0] do_opt,
  output logic       equal_to,
  output logic       eq_press,
  output logic       sw_chg
);

  logic [10:0] sw_value;
  logic        key_chg;

  debounce_cell #(
    .WIDTH       (11),
    .RESET_VAL   (11'd0),
    .DB_CYCLES   (DB_CYCLES),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sw_cell (
    .clk   (clk),
    .rst_n (ac),
    .din   ({sw_a, sw_b, sw_op}),
    .value (sw_value),
    .chg   (sw_chg)
  );

  debounce_cell #(
    .WIDTH       (1),
    .RESET_VAL   (1'b1),
    .DB_CYCLES   (DB_CYCLES),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_key_cell (
    .clk   (clk),
    .rst_n (ac),
    .din   (key_eq),
    .value (equal_to),
    .chg   (key_chg)
  );

  assign opt_a  = sw_value[10:7];
  assign opt_b  = sw_value[6:3];
  assign do_opt = sw_value[2:0];

  // Both operands are flop outputs; a key commit to 0 is a press, to 1 a release.
  assign eq_press = key_chg & ~equal_to;

endmodule

`default_nettype wire
